player_fsm_gen: RTL and testbench

Parametrised next-generation fighter controller. Owns one player's state machine, horizontal position, stun timing and hit/hurt box geometry. All timing is counted in frames using an explicit `frame_tick` strobe, not a free-running counter. One instance per side sits between the input/debounce logic and the collision/render logic.

---
 rtl/player_fsm_gen.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_player_fsm_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_fsm_gen.sv
// One fighter's state machine, horizontal position, stun timing and hit/hurt box geometry.
// Define PLAYER_INPUT_BUFFER_EN to remember an attack press made during PULL or stun.
module player_fsm_gen #(
    parameter int SIDE       = 0,
    parameter int X_W        = 10,
    parameter int X_MIN      = 10,
    parameter int X_MAX      = 517,
    parameter int X_START_L  = 100,
    parameter int X_START_R  = 427,
    parameter int POS_Y      = 170,
    parameter int SPRITE_W   = 113,
    parameter int SPEED_FWD  = 3,
    parameter int SPEED_BACK = 2,
    parameter int B_START_F  = 5,
    parameter int B_ACTIVE_F = 2,
    parameter int B_PULL_F   = 16,
    parameter int D_START_F  = 4,
    parameter int D_ACTIVE_F = 3,
    parameter int D_PULL_F   = 15,
    parameter int HIT_B_F    = 15,
    parameter int HIT_D_F    = 14,
    parameter int BLK_B_F    = 13,
    parameter int BLK_D_F    = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           frame_tick_i,
    input  logic           left_i,
    input  logic           right_i,
    input  logic           attack_i,
    input  logic [1:0]     hit_flag_i,
    input  logic           block_avail_i,
    output logic [X_W-1:0] posx_o,
    output logic [X_W-1:0] posy_o,
    output logic [3:0]     state_o,
    output logic [5:0]     state_frame_o,
    output logic           hit_active_o,
    output logic [X_W-1:0] hit_x1_o,
    output logic [X_W-1:0] hit_x2_o,
    output logic [X_W-1:0] hit_y1_o,
    output logic [X_W-1:0] hit_y2_o,
    output logic [X_W-1:0] hurt_x1_o,
    output logic [X_W-1:0] hurt_x2_o,
    output logic [X_W-1:0] hurt_y1_o,
    output logic [X_W-1:0] hurt_y2_o
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MOVEFWD   = 4'd1,
        ST_MOVEBACK  = 4'd2,
        ST_B_START   = 4'd3,
        ST_B_ACTIVE  = 4'd4,
        ST_B_PULL    = 4'd5,
        ST_D_START   = 4'd6,
        ST_D_ACTIVE  = 4'd7,
        ST_D_PULL    = 4'd8,
        ST_HITSTUN   = 4'd9,
        ST_BLOCKSTUN = 4'd10
    } state_t;

    localparam logic           MIRROR  = (SIDE != 0);
    localparam logic [X_W:0]   XMIN_W  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]   XMAX_W  = (X_W+1)'(X_MAX);
    localparam logic [X_W-1:0] XMIN_X  = X_W'(X_MIN);
    localparam logic [X_W-1:0] XMAX_X  = X_W'(X_MAX);
    localparam logic [X_W:0]   FWD_W   = (X_W+1)'(SPEED_FWD);
    localparam logic [X_W:0]   BACK_W  = (X_W+1)'(SPEED_BACK);
    localparam logic [X_W-1:0] START_X = MIRROR ? X_W'(X_START_R) : X_W'(X_START_L);

    // Horizontal box edges relative to posx, mirrored about the sprite for the right player.
    localparam int BH_L = MIRROR ? (SPRITE_W - 113) : 35;
    localparam int BH_R = MIRROR ? (SPRITE_W - 35)  : 113;
    localparam int DH_L = MIRROR ? (SPRITE_W - 95)  : 62;
    localparam int DH_R = MIRROR ? (SPRITE_W - 62)  : 95;
    localparam int HU_L = MIRROR ? (SPRITE_W - 81)  : 28;
    localparam int HU_R = MIRROR ? (SPRITE_W - 28)  : 81;

    state_t         state_q, state_d;
    logic [5:0]     sf_q, sf_d;
    logic [5:0]     stun_len_q, stun_len_d;
    logic [X_W-1:0] posx_q, posx_d;
    logic           hit_active_q, hit_active_d;

    logic           fwd_key_s, back_key_s, dir_fwd_s, dir_back_s;
    logic           hit_valid_s, in_stun_s, hit_s, hit_dir_s;
    logic           timed_s, exit_s, changed_s, attack_eff_s;
    logic [6:0]     phase_len_s;

    function automatic logic [X_W-1:0] step_up(input logic [X_W-1:0] p, input logic [X_W:0] amt);
        logic [X_W:0] s;
        s = {1'b0, p} + amt;
        if (s > XMAX_W) begin
            return XMAX_X;
        end else begin
            return s[X_W-1:0];
        end
    endfunction

    function automatic logic [X_W-1:0] step_dn(input logic [X_W-1:0] p, input logic [X_W:0] amt);
        logic [X_W:0] d;
        d = {1'b0, p} - amt;
        if (d[X_W] || (d < XMIN_W)) begin
            return XMIN_X;
        end else begin
            return d[X_W-1:0];
        end
    endfunction

    function automatic state_t choose_next(input state_t cur, input logic atk,
                                           input logic fwd, input logic back);
        state_t nxt;
        if (atk) begin
            if ((cur == ST_MOVEFWD) || (cur == ST_MOVEBACK)) begin
                nxt = ST_D_START;
            end else begin
                nxt = ST_B_START;
            end
        end else if (fwd) begin
            nxt = ST_MOVEFWD;
        end else if (back) begin
            nxt = ST_MOVEBACK;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // Holding both keys means back, so back wins over forward.
    assign fwd_key_s   = MIRROR ? left_i : right_i;
    assign back_key_s  = MIRROR ? right_i : left_i;
    assign dir_back_s  = back_key_s;
    assign dir_fwd_s   = fwd_key_s & ~back_key_s;

    assign hit_valid_s = (hit_flag_i == 2'b01) || (hit_flag_i == 2'b10);
    assign hit_dir_s   = (hit_flag_i == 2'b10);
    assign in_stun_s   = (state_q == ST_HITSTUN) || (state_q == ST_BLOCKSTUN);
    assign hit_s       = hit_valid_s & ~in_stun_s;
    assign exit_s      = ({1'b0, sf_q} + 7'd1) >= phase_len_s;

    // Phase length of the current timed state.
    always_comb begin
        phase_len_s = 7'd0;
        timed_s     = 1'b1;
        case (state_q)
            ST_B_START:   phase_len_s = 7'(B_START_F);
            ST_B_ACTIVE:  phase_len_s = 7'(B_ACTIVE_F);
            ST_B_PULL:    phase_len_s = 7'(B_PULL_F);
            ST_D_START:   phase_len_s = 7'(D_START_F);
            ST_D_ACTIVE:  phase_len_s = 7'(D_ACTIVE_F);
            ST_D_PULL:    phase_len_s = 7'(D_PULL_F);
            ST_HITSTUN:   phase_len_s = {1'b0, stun_len_q};
            ST_BLOCKSTUN: phase_len_s = {1'b0, stun_len_q};
            default:      timed_s     = 1'b0;
        endcase
    end

    // Next state: hit, then timed exit, then input choice.
    always_comb begin
        state_d    = state_q;
        stun_len_d = stun_len_q;
        if (hit_s) begin
            if ((state_q == ST_MOVEBACK) && block_avail_i) begin
                state_d    = ST_BLOCKSTUN;
                stun_len_d = hit_dir_s ? 6'(BLK_D_F) : 6'(BLK_B_F);
            end else begin
                state_d    = ST_HITSTUN;
                stun_len_d = hit_dir_s ? 6'(HIT_D_F) : 6'(HIT_B_F);
            end
        end else if (timed_s) begin
            if (exit_s) begin
                case (state_q)
                    ST_B_START:  state_d = ST_B_ACTIVE;
                    ST_B_ACTIVE: state_d = ST_B_PULL;
                    ST_D_START:  state_d = ST_D_ACTIVE;
                    ST_D_ACTIVE: state_d = ST_D_PULL;
                    default:     state_d = choose_next(state_q, attack_eff_s, dir_fwd_s, dir_back_s);
                endcase
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = choose_next(state_q, attack_i, dir_fwd_s, dir_back_s);
        end
    end

    // Frame counter, position and hitbox-live flag follow the state being entered.
    always_comb begin
        changed_s    = hit_s || (state_d != state_q);
        sf_d         = sf_q;
        posx_d       = posx_q;
        hit_active_d = (state_d == ST_B_ACTIVE) || (state_d == ST_D_ACTIVE);
        if (changed_s) begin
            sf_d = 6'd0;
        end else if (sf_q == 6'd63) begin
            sf_d = 6'd63;
        end else begin
            sf_d = sf_q + 6'd1;
        end
        case (state_d)
            ST_MOVEFWD:  posx_d = MIRROR ? step_dn(posx_q, FWD_W) : step_up(posx_q, FWD_W);
            ST_MOVEBACK: posx_d = MIRROR ? step_up(posx_q, BACK_W) : step_dn(posx_q, BACK_W);
            default:     posx_d = posx_q;
        endcase
    end

`ifdef PLAYER_INPUT_BUFFER_EN
    logic atk_prev_q, atk_buf_q, atk_buf_d, buf_state_s;

    assign buf_state_s  = (state_q == ST_B_PULL) || (state_q == ST_D_PULL) || in_stun_s;
    assign attack_eff_s = attack_i | atk_buf_q;

    // Buffer arms on a rising attack edge and is consumed by any state change.
    always_comb begin
        atk_buf_d = atk_buf_q;
        if (changed_s) begin
            atk_buf_d = 1'b0;
        end else if (buf_state_s && attack_i && !atk_prev_q) begin
            atk_buf_d = 1'b1;
        end else begin
            atk_buf_d = atk_buf_q;
        end
    end

    // Buffer registers, advanced once per frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            atk_prev_q <= 1'b0;
            atk_buf_q  <= 1'b0;
        end else if (frame_tick_i) begin
            atk_prev_q <= attack_i;
            atk_buf_q  <= atk_buf_d;
        end
    end
`else
    assign attack_eff_s = attack_i;
`endif

    // Player registers, advanced once per frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sf_q         <= 6'd0;
            stun_len_q   <= 6'd0;
            posx_q       <= START_X;
            hit_active_q <= 1'b0;
        end else if (frame_tick_i) begin
            state_q      <= state_d;
            sf_q         <= sf_d;
            stun_len_q   <= stun_len_d;
            posx_q       <= posx_d;
            hit_active_q <= hit_active_d;
        end
    end

    // Box geometry straight from the registered state and position.
    always_comb begin
        hit_x1_o = '0;
        hit_x2_o = '0;
        hit_y1_o = '0;
        hit_y2_o = '0;
        if (hit_active_q) begin
            if (state_q == ST_D_ACTIVE) begin
                hit_x1_o = posx_q + X_W'(DH_L);
                hit_x2_o = posx_q + X_W'(DH_R);
                hit_y1_o = X_W'(POS_Y + 6);
                hit_y2_o = X_W'(POS_Y + 110);
            end else begin
                hit_x1_o = posx_q + X_W'(BH_L);
                hit_x2_o = posx_q + X_W'(BH_R);
                hit_y1_o = X_W'(POS_Y + 24);
                hit_y2_o = X_W'(POS_Y + 57);
            end
        end else begin
            hit_x1_o = '0;
            hit_x2_o = '0;
        end
    end

    assign hurt_x1_o     = posx_q + X_W'(HU_L);
    assign hurt_x2_o     = posx_q + X_W'(HU_R);
    assign hurt_y1_o     = X_W'(POS_Y);
    assign hurt_y2_o     = X_W'(POS_Y + 150);
    assign posx_o        = posx_q;
    assign posy_o        = X_W'(POS_Y);
    assign state_o       = state_q;
    assign state_frame_o = sf_q;
    assign hit_active_o  = hit_active_q;

endmodule

// File: tb/tb_player_fsm_gen.sv
// Directed bench for player_fsm_gen: a left (SIDE=0) and a right (SIDE=1) instance, scoreboarded per frame tick.
module tb_player_fsm_gen;

    logic clk = 1'b0;
    logic rst, ft;
    logic l0, r0, a0, ba0, l1, r1, a1, ba1;
    logic [1:0] hf0, hf1;
    logic [9:0] px0, py0, hx10, hx20, hy10, hy20, ux10, ux20, uy10, uy20;
    logic [9:0] px1, py1, hx11, hx21, hy11, hy21, ux11, ux21, uy11, uy21;
    logic [3:0] st0, st1;
    logic [5:0] sf0, sf1;
    logic       ha0, ha1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit    side;
        string tag;
        int    st;
        int    px;
        int    ha;
        int    sf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    player_fsm_gen #(.SIDE(0)) u0 (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(ft), .left_i(l0), .right_i(r0), .attack_i(a0),
        .hit_flag_i(hf0), .block_avail_i(ba0), .posx_o(px0), .posy_o(py0), .state_o(st0),
        .state_frame_o(sf0), .hit_active_o(ha0), .hit_x1_o(hx10), .hit_x2_o(hx20),
        .hit_y1_o(hy10), .hit_y2_o(hy20), .hurt_x1_o(ux10), .hurt_x2_o(ux20),
        .hurt_y1_o(uy10), .hurt_y2_o(uy20));

    player_fsm_gen #(.SIDE(1)) u1 (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(ft), .left_i(l1), .right_i(r1), .attack_i(a1),
        .hit_flag_i(hf1), .block_avail_i(ba1), .posx_o(px1), .posy_o(py1), .state_o(st1),
        .state_frame_o(sf1), .hit_active_o(ha1), .hit_x1_o(hx11), .hit_x2_o(hx21),
        .hit_y1_o(hy11), .hit_y2_o(hy21), .hurt_x1_o(ux11), .hurt_x2_o(ux21),
        .hurt_y1_o(uy11), .hurt_y2_o(uy21));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input bit side, input string tag, input int st, input int px,
                            input int ha, input int sf);
        exp_t e;
        e.side = side; e.tag = tag; e.st = st; e.px = px; e.ha = ha; e.sf = sf;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.side == 1'b0) begin
                chk({e.tag, "/state"}, 32'(st0), 32'(e.st));
                chk({e.tag, "/posx"},  32'(px0), 32'(e.px));
                chk({e.tag, "/hitact"}, 32'(ha0), 32'(e.ha));
                if (e.sf >= 0) chk({e.tag, "/sframe"}, 32'(sf0), 32'(e.sf));
            end else begin
                chk({e.tag, "/state"}, 32'(st1), 32'(e.st));
                chk({e.tag, "/posx"},  32'(px1), 32'(e.px));
                chk({e.tag, "/hitact"}, 32'(ha1), 32'(e.ha));
                if (e.sf >= 0) chk({e.tag, "/sframe"}, 32'(sf1), 32'(e.sf));
            end
        end
    endtask

    task automatic tick();
        ft = 1'b1;
        @(posedge clk);
        #1;
        ft = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        {l0, r0, a0, ba0, l1, r1, a1, ba1} = 8'd0;
        hf0 = 2'b00; hf1 = 2'b00; ft = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // reset state and static geometry
        exp_push(0, "rst_l", 0, 100, 0, 0);
        exp_push(1, "rst_r", 0, 427, 0, 0);
        drain();
        chk("posy", 32'(py0), 32'd170);
        chk("hurt_x1_l", 32'(ux10), 32'd128);
        chk("hurt_x2_l", 32'(ux20), 32'd181);
        chk("hurt_y2_l", 32'(uy20), 32'd320);
        chk("hurt_x1_r", 32'(ux11), 32'd459);
        chk("hurt_x2_r", 32'(ux21), 32'd512);
        chk("hit_x1_idle", 32'(hx10), 32'd0);

        // idle for 10 ticks
        for (int i = 1; i <= 10; i++) begin
            exp_push(0, "idle", 0, 100, 0, i);
            tick();
        end

        // forward then both keys (= back)
        r0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_push(0, "fwd", 1, 100 + 3 * i, 0, i - 1);
            tick();
        end
        l0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_push(0, "both", 2, 115 - 2 * i, 0, i - 1);
            tick();
        end
        l0 = 1'b0; r0 = 1'b0;
        exp_push(0, "stop", 0, 109, 0, 0);
        tick();

        // basic attack: 5 start, 2 active, 16 pull
        a0 = 1'b1;
        exp_push(0, "b_atk", 3, 109, 0, 0);
        tick();
        a0 = 1'b0;
        for (int k = 2; k <= 24; k++) begin
            exp_push(0, "b_seq", (k <= 5) ? 3 : (k <= 7) ? 4 : (k <= 23) ? 5 : 0, 109,
                     (k == 6 || k == 7) ? 1 : 0, -1);
            tick();
            if (k == 5) chk("hit_x1_start", 32'(hx10), 32'd0);
            if (k == 6) begin
                chk("bhit_x1", 32'(hx10), 32'd144);
                chk("bhit_x2", 32'(hx20), 32'd222);
                chk("bhit_y1", 32'(hy10), 32'd194);
                chk("bhit_y2", 32'(hy20), 32'd227);
            end
        end

        // hit_flag 11 ignored, then basic hit from IDLE -> 15 ticks hitstun
        hf0 = 2'b11;
        exp_push(0, "hf11", 0, 109, 0, -1);
        tick();
        hf0 = 2'b01;
        exp_push(0, "hit_b", 9, 109, 0, 0);
        tick();
        hf0 = 2'b00;
        for (int j = 1; j <= 15; j++) begin
            exp_push(0, "hitstun", (j <= 14) ? 9 : 0, 109, 0, -1);
            tick();
        end

        // right player: back, directional hit while blocking -> 12 ticks blockstun
        r1 = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            exp_push(1, "r_back", 2, 427 + 2 * i, 0, -1);
            tick();
        end
        hf1 = 2'b10; ba1 = 1'b1;
        exp_push(1, "r_blk", 10, 431, 0, 0);
        tick();
        r1 = 1'b0; hf1 = 2'b00;
        for (int j = 1; j <= 12; j++) begin
            if (j == 5) hf1 = 2'b01;
            exp_push(1, "r_blkstun", (j <= 11) ? 10 : 0, 431, 0, (j == 5) ? 5 : -1);
            tick();
            hf1 = 2'b00;
        end

        // right player mirrored basic hitbox
        a1 = 1'b1;
        exp_push(1, "r_atk", 3, 431, 0, 0);
        tick();
        a1 = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            exp_push(1, "r_bseq", (k <= 5) ? 3 : 4, 431, (k == 6) ? 1 : 0, -1);
            tick();
        end
        chk("r_bhit_x1", 32'(hx11), 32'd431);
        chk("r_bhit_x2", 32'(hx21), 32'd509);

        // walk the left player to 516, then into the clamp
        r0 = 1'b1;
        for (int i = 1; i <= 135; i++) begin
            if (i == 135) exp_push(0, "walk", 1, 514, 0, -1);
            tick();
        end
        r0 = 1'b0; l0 = 1'b1;
        tick();
        exp_push(0, "walk_back", 2, 510, 0, 1);
        tick();
        l0 = 1'b0; r0 = 1'b1;
        tick();
        exp_push(0, "at516", 1, 516, 0, 1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            exp_push(0, "clamp", 1, 517, 0, 1 + i);
            tick();
        end

        // no frame_tick for 20 cycles: nothing moves
        repeat (20) @(posedge clk);
        #1;
        exp_push(0, "hold", 1, 517, 0, 5);
        drain();

        // reset in the middle of a directional attack
        r0 = 1'b0; a0 = 1'b1;
        exp_push(0, "d_atk", 6, 517, 0, 0);
        tick();
        a0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_push(0, "rst_mid", 0, 100, 0, 0);
        drain();

        // directional attack, then attack pulse in D_PULL frame 5
        r0 = 1'b1;
        exp_push(0, "b_fwd", 1, 103, 0, 0);
        tick();
        a0 = 1'b1;
        exp_push(0, "b_datk", 6, 103, 0, 0);
        tick();
        a0 = 1'b0; r0 = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            exp_push(0, "d_seq", (k <= 4) ? 6 : 7, 103, (k == 5) ? 1 : 0, -1);
            tick();
        end
        chk("dhit_x1", 32'(hx10), 32'd165);
        chk("dhit_x2", 32'(hx20), 32'd198);
        chk("dhit_y1", 32'(hy10), 32'd176);
        chk("dhit_y2", 32'(hy20), 32'd280);
        found = 0;
        for (int w = 0; (w < 40) && (found == 0); w++) begin
            if ((st0 == 4'd8) && (sf0 == 6'd5)) found = 1;
            else tick();
        end
        chk("dpull_wait", 32'(found), 32'd1);
        a0 = 1'b1;
        exp_push(0, "pulse", 8, 103, 0, 6);
        tick();
        a0 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            exp_push(0, "pull", 8, 103, 0, -1);
            tick();
        end
`ifdef PLAYER_INPUT_BUFFER_EN
        exp_push(0, "pull_exit", 3, 103, 0, 0);
`else
        exp_push(0, "pull_exit", 0, 103, 0, 0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
